// File: rtl/lsu_memctrl_pkg.sv
// rtl/lsu_memctrl_pkg.sv - shared FSM states, funct3 codes and strobe constants for the LSU
package lsu_memctrl_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;

  localparam logic [2:0] F_LB     = 3'b000;
  localparam logic [2:0] F_LH     = 3'b001;
  localparam logic [2:0] F_LW     = 3'b010;
  localparam logic [2:0] F_LD     = 3'b011;
  localparam logic [2:0] F_LBU    = 3'b100;
  localparam logic [2:0] F_LHU    = 3'b101;
  localparam logic [2:0] F_LWU    = 3'b110;
  localparam logic [2:0] F_LD_ALT = 3'b111;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  function automatic logic [7:0] size_strb(input logic [1:0] size);
    case (size)
      SZ_B:    return STRB_B;
      SZ_H:    return STRB_H;
      SZ_W:    return STRB_W;
      default: return STRB_D;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return off[0] == 1'b0;
      SZ_W:    return off[1:0] == 2'b00;
      default: return off == 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ldfmt.sv
// rtl/lsu_ldfmt.sv - load lane extraction and sign/zero extension
module lsu_ldfmt
  import lsu_memctrl_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [2:0]  func,
  output logic [63:0] result
);

  logic [63:0] lane;

  // Bring the addressed byte lane down to bit 0 before sizing.
  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    result = lane;
    case (func)
      F_LB:           result = {{56{lane[7]}}, lane[7:0]};
      F_LH:           result = {{48{lane[15]}}, lane[15:0]};
      F_LW:           result = {{32{lane[31]}}, lane[31:0]};
      F_LBU:          result = {56'd0, lane[7:0]};
      F_LHU:          result = {48'd0, lane[15:0]};
      F_LWU:          result = {32'd0, lane[31:0]};
      F_LD, F_LD_ALT: result = lane;
    endcase
  end

endmodule

// File: rtl/lsu_memctrl.sv
// rtl/lsu_memctrl.sv - load/store unit bus controller with request/response FSM and timeout
module lsu_memctrl
  import lsu_memctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CPU_WIDTH   = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_lsu_valid,
  input  logic                 i_lsu_lden,
  input  logic                 i_lsu_sten,
  input  logic [2:0]           i_lsu_func,
  input  logic [CPU_WIDTH-1:0] i_lsu_exres,
  input  logic [CPU_WIDTH-1:0] i_lsu_stdata,
  output logic [CPU_WIDTH-1:0] o_lsu_lsres,
  output logic                 o_lsu_stall,
  output logic                 o_lsu_err,
  output logic                 o_mem_valid,
  input  logic                 i_mem_ready,
  output logic                 o_mem_we,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic [63:0]          o_mem_wdata,
  output logic [7:0]           o_mem_wstrb,
  input  logic                 i_mem_rvalid,
  input  logic [63:0]          i_mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       req_off;
  logic [2:0]       req_func;
  logic             mem_op;
  logic             aligned;
  logic [1:0]       size;
  logic [2:0]       off;
  logic [63:0]      st64;
  logic [63:0]      fmt;

  assign mem_op  = i_lsu_valid & (i_lsu_lden | i_lsu_sten);
  assign size    = i_lsu_func[1:0];
  assign off     = i_lsu_exres[2:0];
  assign aligned = is_aligned(size, off);
  assign st64    = 64'(i_lsu_stdata);

  lsu_ldfmt u_ldfmt (
    .rdata  (i_mem_rdata),
    .off    (req_off),
    .func   (req_func),
    .result (fmt)
  );

  // Stall rises in the same cycle an aligned op is presented so the pipe freezes immediately.
  assign o_lsu_stall = (state == ST_IDLE && mem_op && aligned) ||
                       state == ST_REQ || state == ST_WAIT;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      req_off     <= '0;
      req_func    <= '0;
      o_lsu_lsres <= '0;
      o_lsu_err   <= 1'b0;
      o_mem_valid <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wstrb <= '0;
    end else begin
      o_lsu_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_op && aligned) begin
            req_off     <= off;
            req_func    <= i_lsu_func;
            o_mem_valid <= 1'b1;
            o_mem_we    <= i_lsu_sten;
            o_mem_addr  <= {i_lsu_exres[CPU_WIDTH-1:3], 3'b000};
            o_mem_wdata <= st64 << {off, 3'b000};
            o_mem_wstrb <= size_strb(size) << off;
            state       <= ST_REQ;
          end else if (mem_op) begin
            o_lsu_err <= 1'b1;
          end
        end
        ST_REQ: begin
          // Any rvalid seen here is ignored; responses are only accepted from WAIT.
          if (i_mem_ready) begin
            o_mem_valid <= 1'b0;
            wait_cnt    <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_mem_rvalid) begin
            if (!o_mem_we) o_lsu_lsres <= CPU_WIDTH'(fmt);
            state <= ST_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            o_lsu_err <= 1'b1;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_memctrl.sv
// tb/tb_lsu_memctrl.sv - randomized self-checking bench for lsu_memctrl against a byte-level model
module tb_lsu_memctrl;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_lden, lsu_sten;
  logic [2:0]  lsu_func;
  logic [63:0] lsu_exres, lsu_stdata, lsres;
  logic        stall, err, mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wstrb;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] model_lsres = '0;

  always #5 clk = ~clk;

  lsu_memctrl #(.TIMEOUT_CYC(TO), .CPU_WIDTH(64)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lsu_valid(lsu_valid), .i_lsu_lden(lsu_lden), .i_lsu_sten(lsu_sten),
    .i_lsu_func(lsu_func), .i_lsu_exres(lsu_exres), .i_lsu_stdata(lsu_stdata),
    .o_lsu_lsres(lsres), .o_lsu_stall(stall), .o_lsu_err(err),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_we(mem_we),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
    .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nbytes(input logic [2:0] func);
    return (func[1:0] == 2'd3) ? 8 : (1 << func[1:0]);
  endfunction

  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input int off, input logic [2:0] func);
    int          n;
    bit          sgn;
    logic [63:0] v;
    n   = nbytes(func);
    sgn = (func[2] == 1'b0) || (func == 3'b111);
    v   = rdata >> (8 * off);
    if (n < 8) begin
      v = v % (64'd1 << (8 * n));
      if (sgn && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    end
    return v;
  endfunction

  task automatic do_access(input bit is_st, input logic [2:0] func, input logic [63:0] addr,
                           input logic [63:0] stdata, input logic [63:0] rdata,
                           input int rdy_dly, input int rv_dly, input bit tmo);
    int          off, n;
    bit          al;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata, e_res, e_addr;
    off     = int'(addr[2:0]);
    n       = nbytes(func);
    al      = (off % n) == 0;
    e_strb  = 8'(((1 << n) - 1) << off);
    e_wdata = stdata << (8 * off);
    e_res   = exp_load(rdata, off, func);
    e_addr  = addr - 64'(off);
    lsu_valid = 1'b1; lsu_lden = ~is_st; lsu_sten = is_st;
    lsu_func = func; lsu_exres = addr; lsu_stdata = stdata;
    #1;
    n_cmp++; if (stall !== al) begin n_err++; $display("FAIL issue_stall: got %b want %b", stall, al); end
    step();
    lsu_valid = 1'b0; lsu_exres = {$urandom, $urandom}; lsu_stdata = {$urandom, $urandom};
    if (!al) begin
      n_cmp++; if ({err, mem_valid, stall} !== 3'b100) begin n_err++; $display("FAIL misalign_err: got {err,valid,stall}=%b want 100", {err, mem_valid, stall}); end
      step();
      n_cmp++; if ({err, mem_valid} !== 2'b00) begin n_err++; $display("FAIL misalign_after: got {err,valid}=%b want 00", {err, mem_valid}); end
      return;
    end
    for (int i = 0; i <= rdy_dly; i++) begin
      n_cmp++;
      if ({stall, err, mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {3'b101, is_st, e_addr, e_wdata, e_strb}) begin
        n_err++;
        $display("FAIL req_fields: got v=%b we=%b a=%h d=%h s=%h want we=%b a=%h d=%h s=%h",
                 mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, is_st, e_addr, e_wdata, e_strb);
      end
      if (i == rdy_dly) begin
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = ~rdata;
      end
      step();
    end
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    n_cmp++; if ({mem_valid, stall} !== 2'b01) begin n_err++; $display("FAIL wait_entry: got {valid,stall}=%b want 01", {mem_valid, stall}); end
    if (tmo) begin
      for (int i = 0; i < TO; i++) begin
        n_cmp++; if ({stall, err} !== 2'b10) begin n_err++; $display("FAIL wait_hold: cycle %0d got {stall,err}=%b want 10", i, {stall, err}); end
        step();
      end
    end else begin
      for (int i = 0; i < rv_dly; i++) begin
        n_cmp++; if ({stall, err} !== 2'b10) begin n_err++; $display("FAIL wait_hold: cycle %0d got {stall,err}=%b want 10", i, {stall, err}); end
        step();
      end
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0;
      if (!is_st) model_lsres = e_res;
    end
    n_cmp++; if ({stall, err} !== {1'b0, tmo}) begin n_err++; $display("FAIL done_flags: got {stall,err}=%b want 0%b", {stall, err}, tmo); end
    n_cmp++; if (lsres !== model_lsres) begin n_err++; $display("FAIL done_lsres: got %h want %h", lsres, model_lsres); end
    step();
    n_cmp++; if ({err, mem_valid, stall} !== 3'b000 || lsres !== model_lsres) begin n_err++; $display("FAIL back_idle: got {err,valid,stall}=%b lsres=%h want 000 %h", {err, mem_valid, stall}, lsres, model_lsres); end
  endtask

  task automatic test_reset();
    rst = 1'b1; lsu_valid = 1'b0; lsu_lden = 1'b0; lsu_sten = 1'b0; lsu_func = '0;
    lsu_exres = '0; lsu_stdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    rst = 1'b0;
    n_cmp++; if ({lsres, mem_valid, err, stall} !== 67'd0) begin n_err++; $display("FAIL reset_state: got lsres=%h valid=%b err=%b stall=%b want all 0", lsres, mem_valid, err, stall); end
  endtask

  task automatic test_ld_double();
    do_access(1'b0, 3'b011, 64'h8000_0008, 64'd0, 64'h1122334455667788, 0, 0, 1'b0);
    n_cmp++; if (lsres !== 64'h1122334455667788) begin n_err++; $display("FAIL ld_result: got %h want 1122334455667788", lsres); end
  endtask

  task automatic test_lb_sign();
    do_access(1'b0, 3'b000, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0, 1'b0);
    n_cmp++; if (lsres !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL lb_sign: got %h want ffffffffffffff80", lsres); end
    do_access(1'b0, 3'b100, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1, 2, 1'b0);
    n_cmp++; if (lsres !== 64'h80) begin n_err++; $display("FAIL lbu_zero: got %h want 80", lsres); end
  endtask

  task automatic test_sh_store();
    do_access(1'b1, 3'b001, 64'h8000_0006, 64'hABCD, 64'd0, 0, 1, 1'b0);
  endtask

  task automatic test_misaligned();
    do_access(1'b0, 3'b010, 64'h8000_0002, 64'd0, 64'd0, 0, 0, 1'b0);
    do_access(1'b1, 3'b011, 64'h8000_0004, 64'h55, 64'd0, 0, 0, 1'b0);
  endtask

  task automatic test_ready_timeout();
    do_access(1'b1, 3'b011, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'd0, 5, 0, 1'b1);
    do_access(1'b0, 3'b010, 64'h8000_0014, 64'd0, 64'hDEAD_BEEF_0000_0000, 2, 0, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    lsu_valid = 1'b1; lsu_lden = 1'b1; lsu_sten = 1'b0; lsu_func = 3'b011; lsu_exres = 64'h8000_0020;
    step();
    lsu_valid = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; model_lsres = '0;
    n_cmp++; if ({lsres, mem_valid, err, stall} !== 67'd0) begin n_err++; $display("FAIL rst_wait: got lsres=%h valid=%b err=%b stall=%b want all 0", lsres, mem_valid, err, stall); end
    mem_rvalid = 1'b1; mem_rdata = 64'hFEED_FACE_CAFE_F00D;
    step();
    mem_rvalid = 1'b0;
    step();
    n_cmp++; if ({lsres, mem_valid, err, stall} !== 67'd0) begin n_err++; $display("FAIL late_rvalid: got lsres=%h valid=%b err=%b stall=%b want all 0", lsres, mem_valid, err, stall); end
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1'(i % 2); lsu_lden = (i % 2 == 0); lsu_sten = (i == 2);
      if (i % 2 == 1) begin lsu_lden = 1'b0; lsu_sten = 1'b0; end
      lsu_func = 3'($urandom_range(0, 7)); lsu_exres = {$urandom, $urandom};
      #1;
      n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL pass_stall: iter %0d got %b want 0", i, stall); end
      step();
      n_cmp++; if ({mem_valid, err} !== 2'b00 || lsres !== model_lsres) begin n_err++; $display("FAIL pass_hold: iter %0d got valid=%b err=%b lsres=%h want 0 0 %h", i, mem_valid, err, lsres, model_lsres); end
    end
    lsu_valid = 1'b0; lsu_lden = 1'b0; lsu_sten = 1'b0;
  endtask

  task automatic test_random();
    bit          is_st;
    logic [2:0]  func;
    logic [63:0] addr;
    for (int k = 0; k < 60; k++) begin
      is_st = ($urandom_range(0, 2) == 0);
      func  = is_st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      addr  = 64'h8000_0000 + 64'($urandom_range(0, 63));
      do_access(is_st, func, addr, {$urandom, $urandom}, {$urandom, $urandom},
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ld_double();
    test_lb_sign();
    test_sh_store();
    test_misaligned();
    test_ready_timeout();
    test_lb_sign();
    test_reset_in_wait();
    test_passthrough();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_memctrl.md
LSU_MEMCTRL -- requirements
Module: lsu_memctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, giving the max cycles in WAIT before abort.
REQ-002 SHALL have parameter CPU_WIDTH, default 64, giving the datapath and address width.
REQ-003 SHALL have port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_lsu_valid  in  1  instruction present in LS stage.
REQ-006 SHALL have port i_lsu_lden  in  1  load op.
REQ-007 SHALL have port i_lsu_sten  in  1  store op.
REQ-008 SHALL have port i_lsu_func  in  3  funct3 size/sign code.
REQ-009 SHALL have port i_lsu_exres  in  CPU_WIDTH  effective byte address.
REQ-010 SHALL have port i_lsu_stdata  in  CPU_WIDTH  store data, rs2.
REQ-011 SHALL have port o_lsu_lsres  out  CPU_WIDTH  formatted load result, feeds LS/WB register.
REQ-012 SHALL have port o_lsu_stall  out  1  freeze upstream pipe and LS/WB capture.
REQ-013 SHALL have port o_lsu_err  out  1  one-cycle pulse: misaligned access or timeout.
REQ-014 SHALL have ports o_mem_valid/i_mem_ready  out/in  1/1  request handshake.
REQ-015 SHALL have ports o_mem_we  out  1, o_mem_addr  out  CPU_WIDTH (low 3 bits zero), o_mem_wdata  out  64, o_mem_wstrb  out  8.
REQ-016 SHALL have ports i_mem_rvalid  in  1, i_mem_rdata  in  64  response, for loads and store acks alike.

Function
REQ-017 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: on i_lsu_valid & (lden|sten) & aligned, go to REQ; if misaligned, pulse o_lsu_err, no bus access, stay IDLE.
REQ-019 Alignment rule: half needs addr[0]=0, word addr[1:0]=0, double addr[2:0]=0.
REQ-020 REQ: hold o_mem_valid=1 and all request fields stable until i_mem_ready=1; then go to WAIT.
REQ-021 WAIT: on i_mem_rvalid go to DONE and capture the formatted result (loads only); count cycles, and at TIMEOUT_CYC pulse o_lsu_err and go to DONE with o_lsu_lsres unchanged.
REQ-022 i_mem_rvalid in the same cycle as the REQ->WAIT transition SHALL be ignored; the response is accepted only in WAIT.
REQ-023 DONE: stall=0 for exactly one cycle, then IDLE; the next access cannot start before IDLE.
REQ-024 o_lsu_stall SHALL be combinational: 1 when (IDLE with aligned mem op pending) or REQ or WAIT; 0 otherwise.
REQ-025 Non-memory or invalid instructions SHALL pass with zero added latency; o_lsu_lsres holds its last value.
REQ-026 Load format: lb/lh/lw/ld (func 000/001/010/011) sign-extend; lbu/lhu/lwu (100/101/110) zero-extend.
REQ-027 Load lanes: byte lane select = addr[2:0]; func 111 SHALL be treated as ld.
REQ-028 Store format: wstrb = {1,3,F,FF}[size] << addr[2:0]; wdata = stdata << 8*addr[2:0].
REQ-029 Minimum memory-op latency: 3 cycles (REQ, WAIT, DONE) with ready=1 and rvalid on the first WAIT cycle.

Reset
REQ-030 i_rst SHALL force IDLE, clear the timeout counter, and set o_lsu_lsres=0, o_mem_valid=0, o_lsu_err=0.
REQ-031 i_rst mid-transaction SHALL abandon it, with no further request and any late rvalid ignored.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the funct3 size/sign codes, and the size-to-strobe constants.
REQ-033 Load extraction/extension SHALL live in one combinational sub-module, lsu_ldfmt.

Verification
REQ-034 ld at 0x80000008, ready=1, rvalid on the first WAIT cycle with rdata=0x1122334455667788 -> lsres=0x1122334455667788 after 3 cycles; stall high for 3 cycles, then low for 1.
REQ-035 lb at 0x80000003, rdata=0x00000000_80000000 -> lsres=0xFFFFFFFFFFFFFF80; lbu at the same address -> 0x80.
REQ-036 sh at 0x80000006, stdata=0xABCD -> wstrb=0xC0, wdata[63:48]=0xABCD, we=1.
REQ-037 lw at 0x80000002 -> err pulse for 1 cycle, o_mem_valid never asserted, stall=0.
REQ-038 ready low for 5 cycles -> addr/wdata/wstrb stable throughout; rvalid never arrives -> err after TIMEOUT_CYC cycles in WAIT, then DONE.
REQ-039 i_rst in WAIT, followed by rvalid -> state IDLE, lsres=0, no stall.
